int_resize_pipe: RTL and testbench
==================================

# int_resize_pipe

Parametrised, pipelined integer width converter. It resizes an `IN_W`-bit integer to `OUT_W`-bit under a per-transaction mode: zero/sign extension, wrapping truncation, or unsigned/signed saturation. A valid/ready handshake, a one-stage output register and overflow statistics make it usable in streaming datapaths. It generalises the fixed 8→16 sign-extend / 8→4 truncate conversion into one configurable, back-pressurable stage.

## Interface
- `IN_W`, default 8: input width, ≥ 2.
- `OUT_W`, default 16: output width, ≥ 2. It may be less than, equal to, or greater than `IN_W`.
- `CNT_W`, default 8: overflow counter width, ≥ 1.

Ports:
- `_i_clk`  in  1  clock. One clock domain; all state updates on its rising edge.
- `_i_rst`  in  1  reset, synchronous, active-high.
- `_i_in_valid`  in  1  an input transaction is offered.
- `_i_in_data`  in  `IN_W`  input value.
- `_i_mode`  in  2  conversion mode, sampled with the data: 0 = unsigned wrap, 1 = signed wrap, 2 = unsigned saturate, 3 = signed saturate.
- `_i_out_ready`  in  1  downstream accepts the output.
- `_i_clear_stats`  in  1  clears the overflow statistics.
- `__output`  out  `OUT_W+CNT_W+4`  concatenation, MSB first:
  - `out_valid` (1)
  - `out_data` (`OUT_W`)
  - `out_ovf` (1)
  - `in_ready` (1)
  - `ovf_sticky` (1)
  - `ovf_count` (`CNT_W`)

## Operation
- **Input acceptance:** `accept = in_valid & in_ready`, with `in_ready = !out_valid | out_ready`. `in_ready` is combinational from registered state and `_i_out_ready` only.
- **Register load:** on `accept`, the output register loads `out_data`, `out_ovf` and `out_valid=1`.
- **Drain:** on `out_valid & out_ready` without `accept`, `out_valid` goes to 0. Data is held otherwise.
- **Interpretation of `in_data`:** unsigned for modes 0 and 2, two's complement for modes 1 and 3.
- **Widening or equal (`OUT_W ≥ IN_W`):**
  - Modes 0 and 2 zero-extend; modes 1 and 3 sign-extend.
  - `out_ovf` is always 0.
- **Narrowing (`OUT_W < IN_W`):**
  - Mode 0/1: `out_data` = low `OUT_W` bits.
  - Mode 2: clamp to `[0, 2^OUT_W−1]`.
  - Mode 3: clamp to `[−2^(OUT_W−1), 2^(OUT_W−1)−1]`.
  - `out_ovf` = 1 iff the interpreted input is not representable in `OUT_W` bits under the mode's signedness. This applies to wrap modes as well, where the value still wraps.
- **Overflow statistics:** on `accept` with computed ovf=1:
  - `ovf_sticky` sets to 1.
  - `ovf_count` increments, saturating at `2^CNT_W−1` (no wrap).
- **`_i_clear_stats`:** zeroes `ovf_sticky` and `ovf_count`. If an overflowing `accept` occurs in the same cycle, the result is `ovf_sticky=1`, `ovf_count=1`: the event is counted after the clear.
- **Reset:** `out_valid=0`, `out_data=0`, `out_ovf=0`, `ovf_sticky=0`, `ovf_count=0`. Hence `in_ready=1` in the first cycle after reset. Reset mid-stream drops the held word without delivering it and overrides clear/accept.

## Timing
- Latency is 1 cycle: data accepted at edge N appears at `__output` after edge N with `out_valid=1`.
- Throughput is one word per cycle while `out_ready=1`.
- Back-pressure:
  - `out_valid=1` with `out_ready=0` forces `in_ready=0`.
  - `out_data`/`out_ovf` stay stable until the transfer completes.
- Simultaneous drain and accept: the register reloads and `out_valid` stays 1, with no bubble.
- `_i_mode` is sampled only on `accept`. Changing it while the register is held does not alter the held word.
- Statistics reflect accepted words from the cycle after the accepting edge.

## Test plan
- **IN_W=8, OUT_W=16:**
  - 0x01 mode 1 → `out_data=0x0001`, `ovf=0`.
  - 0x8A mode 1 → `0xFF8A`.
  - 0x8A mode 0 → `0x008A`, `ovf=0`.
  - Each result appears one cycle after acceptance.
- **IN_W=8, OUT_W=4, input 0x8A:**
  - mode 1 → 0xA, ovf=1.
  - mode 3 → 0x8, ovf=1.
  - mode 2 → 0xF, ovf=1.
  - mode 0 → 0xA, ovf=1.
- **IN_W=8, OUT_W=4, input 0xFF:**
  - mode 1 → 0xF, ovf=0.
  - mode 0 → 0xF, ovf=1.
  - mode 3 → 0xF, ovf=0.
  - Input 0x07 mode 3 → 0x7, ovf=0.
- **Back-pressure:**
  - Hold `out_ready=0` with `in_valid=1` for 3 cycles → `in_ready=0`, first word held unchanged, no other words accepted.
  - Raise `out_ready` → back-to-back words at 1/cycle, none lost or duplicated.
- **Statistics, CNT_W=2:**
  - 5 overflowing accepts → `ovf_count=3` (saturated), `ovf_sticky=1`.
  - `clear_stats` together with an overflowing accept → count=1, sticky=1.
  - `clear_stats` alone → 0/0.
- **Reset mid-stream:** assert `_i_rst` with `out_valid=1` → next cycle `out_valid=0`, `out_data=0`, stats 0, `in_ready=1`.

Source files
------------

// File: rtl/int_resize_pipe.sv
// Pipelined integer width converter: wrap or saturate IN_W -> OUT_W with a
// one-deep valid/ready output register and overflow statistics.
module int_resize_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                     _i_clk,
    input  logic                     _i_rst,
    input  logic                     _i_in_valid,
    input  logic [IN_W-1:0]          _i_in_data,
    input  logic [1:0]               _i_mode,
    input  logic                     _i_out_ready,
    input  logic                     _i_clear_stats,
    output logic [OUT_W+CNT_W+3:0]   __output
);

    logic             outValid;
    logic [OUT_W-1:0] outData;
    logic             outOvf;
    logic             ovfSticky;
    logic [CNT_W-1:0] ovfCount;

    logic             inReady;
    logic             accept;
    logic [OUT_W-1:0] convData;
    logic             convOvf;

    assign inReady = !outValid || _i_out_ready;
    assign accept  = _i_in_valid && inReady;

    generate
        if (OUT_W >= IN_W) begin : g_widen
            // Odd modes are the signed ones; a widened value can never overflow.
            always_comb begin
                convOvf = 1'b0;
                case (_i_mode)
                    2'd1, 2'd3: convData = OUT_W'($signed(_i_in_data));
                    default:    convData = OUT_W'(_i_in_data);
                endcase
            end
        end else begin : g_narrow
            logic [OUT_W-1:0] lowBits;
            logic             uOvf;
            logic             sOvf;

            // Signed fit needs every bit from the new sign position upward to agree.
            always_comb begin
                lowBits = _i_in_data[OUT_W-1:0];
                uOvf    = |_i_in_data[IN_W-1:OUT_W];
                sOvf    = !((&_i_in_data[IN_W-1:OUT_W-1]) || !(|_i_in_data[IN_W-1:OUT_W-1]));
                convData = lowBits;
                convOvf  = uOvf;
                case (_i_mode)
                    2'd0: begin
                        convData = lowBits;
                        convOvf  = uOvf;
                    end
                    2'd1: begin
                        convData = lowBits;
                        convOvf  = sOvf;
                    end
                    2'd2: begin
                        convData = uOvf ? '1 : lowBits;
                        convOvf  = uOvf;
                    end
                    default: begin
                        if (sOvf) begin
                            convData = _i_in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                          : {1'b0, {(OUT_W-1){1'b1}}};
                        end else begin
                            convData = lowBits;
                        end
                        convOvf = sOvf;
                    end
                endcase
            end
        end
    endgenerate

    // Output register: a new word replaces the held one in the same cycle it drains.
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            outValid <= 1'b0;
            outData  <= '0;
            outOvf   <= 1'b0;
        end else if (accept) begin
            outValid <= 1'b1;
            outData  <= convData;
            outOvf   <= convOvf;
        end else if (_i_out_ready) begin
            outValid <= 1'b0;
        end
    end

    // An overflow accepted together with a clear is counted after the clear.
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            ovfSticky <= 1'b0;
            ovfCount  <= '0;
        end else if (accept && convOvf) begin
            ovfSticky <= 1'b1;
            if (_i_clear_stats) begin
                ovfCount <= CNT_W'(1);
            end else if (!(&ovfCount)) begin
                ovfCount <= ovfCount + 1'b1;
            end
        end else if (_i_clear_stats) begin
            ovfSticky <= 1'b0;
            ovfCount  <= '0;
        end
    end

    assign __output = {outValid, outData, outOvf, inReady, ovfSticky, ovfCount};

endmodule

// File: tb/tb_int_resize_pipe.sv
// Self-checking bench for int_resize_pipe: one widening (8->16) and one
// narrowing (8->4, 2-bit counter) instance driven from a directed sequence.
module tb_int_resize_pipe;

    localparam int IN_W = 8;
    localparam int WA   = 16;
    localparam int CA   = 8;
    localparam int WB   = 4;
    localparam int CB   = 2;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              aValid, aReady, aClear;
    logic [IN_W-1:0]   aData;
    logic [1:0]        aMode;
    logic [WA+CA+3:0]  aOut;
    logic              bValid, bReady, bClear;
    logic [IN_W-1:0]   bData;
    logic [1:0]        bMode;
    logic [WB+CB+3:0]  bOut;

    logic              aOutValid, aOutOvf, aInReady, aSticky;
    logic [WA-1:0]     aOutData;
    logic [CA-1:0]     aCount;
    logic              bOutValid, bOutOvf, bInReady, bSticky;
    logic [WB-1:0]     bOutData;
    logic [CB-1:0]     bCount;

    assign {aOutValid, aOutData, aOutOvf, aInReady, aSticky, aCount} = aOut;
    assign {bOutValid, bOutData, bOutOvf, bInReady, bSticky, bCount} = bOut;

    int_resize_pipe #(.IN_W(IN_W), .OUT_W(WA), .CNT_W(CA)) dutWide (
        ._i_clk(clk), ._i_rst(rst), ._i_in_valid(aValid), ._i_in_data(aData),
        ._i_mode(aMode), ._i_out_ready(aReady), ._i_clear_stats(aClear),
        .__output(aOut)
    );

    int_resize_pipe #(.IN_W(IN_W), .OUT_W(WB), .CNT_W(CB)) dutNarrow (
        ._i_clk(clk), ._i_rst(rst), ._i_in_valid(bValid), ._i_in_data(bData),
        ._i_mode(bMode), ._i_out_ready(bReady), ._i_clear_stats(bClear),
        .__output(bOut)
    );

    int   vecCount  = 0;
    int   missCount = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t aExp, bExp;

    logic        mValidA = 1'b0, mValidB = 1'b0;
    logic [15:0] mDataA = '0, mDataB = '0;
    logic        mOvfA = 1'b0, mOvfB = 1'b0;
    logic        mStickyA = 1'b0, mStickyB = 1'b0;
    int          mCountA = 0, mCountB = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] widenExp(input logic [7:0] d, input logic [1:0] m);
        return m[0] ? {{8{d[7]}}, d} : {8'h00, d};
    endfunction

    task automatic updateStats(input logic acc, input logic ovf, input logic clr,
                               input int cap, inout logic sticky, inout int count);
        if (acc && ovf) begin
            sticky = 1'b1;
            count  = clr ? 1 : ((count == cap) ? count : count + 1);
        end else if (clr) begin
            sticky = 1'b0;
            count  = 0;
        end
    endtask

    // One clock: predict acceptance, push expectations, clock, then pop and compare.
    task automatic tick();
        logic accA, accB, rstNow, clrA, clrB;
        exp_t e;
        #2;
        checkOutput("a_in_ready", 32'(aInReady), 32'(!mValidA || aReady));
        checkOutput("b_in_ready", 32'(bInReady), 32'(!mValidB || bReady));
        rstNow = rst;
        clrA   = aClear;
        clrB   = bClear;
        accA   = !rstNow && aValid && (!mValidA || aReady);
        accB   = !rstNow && bValid && (!mValidB || bReady);
        if (accA) qa.push_back(aExp);
        if (accB) qb.push_back(bExp);
        @(posedge clk);
        #1;
        if (rstNow) begin
            mValidA = 1'b0; mDataA = '0; mOvfA = 1'b0; mStickyA = 1'b0; mCountA = 0;
            mValidB = 1'b0; mDataB = '0; mOvfB = 1'b0; mStickyB = 1'b0; mCountB = 0;
            qa.delete();
            qb.delete();
        end else begin
            if (accA) begin
                e = qa.pop_front();
                mValidA = 1'b1; mDataA = e.data; mOvfA = e.ovf;
            end else if (aReady) begin
                mValidA = 1'b0;
            end
            if (accB) begin
                e = qb.pop_front();
                mValidB = 1'b1; mDataB = e.data; mOvfB = e.ovf;
            end else if (bReady) begin
                mValidB = 1'b0;
            end
            updateStats(accA, mOvfA, clrA, (1 << CA) - 1, mStickyA, mCountA);
            updateStats(accB, mOvfB, clrB, (1 << CB) - 1, mStickyB, mCountB);
        end
        checkOutput("a_out_valid", 32'(aOutValid), 32'(mValidA));
        checkOutput("a_out_data",  32'(aOutData),  32'(mDataA));
        checkOutput("a_out_ovf",   32'(aOutOvf),   32'(mOvfA));
        checkOutput("a_sticky",    32'(aSticky),   32'(mStickyA));
        checkOutput("a_count",     32'(aCount),    32'(mCountA));
        checkOutput("b_out_valid", 32'(bOutValid), 32'(mValidB));
        checkOutput("b_out_data",  32'(bOutData),  32'(mDataB[WB-1:0]));
        checkOutput("b_out_ovf",   32'(bOutOvf),   32'(mOvfB));
        checkOutput("b_sticky",    32'(bSticky),   32'(mStickyB));
        checkOutput("b_count",     32'(bCount),    32'(mCountB));
    endtask

    task automatic applyStimulus(input int which, input logic v, input logic [7:0] d,
                                 input logic [1:0] m, input logic [15:0] ed, input logic eo);
        if (which == 0) begin
            aValid = v; aData = d; aMode = m; aExp = '{data: ed, ovf: eo};
        end else begin
            bValid = v; bData = d; bMode = m; bExp = '{data: ed, ovf: eo};
        end
        tick();
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] m;
        $display("[TB] int_resize_pipe bench start");
        rst = 1'b1;
        aValid = 1'b0; aData = '0; aMode = '0; aReady = 1'b1; aClear = 1'b0;
        bValid = 1'b0; bData = '0; bMode = '0; bReady = 1'b1; bClear = 1'b0;
        aExp = '0; bExp = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_a_valid",    32'(aOutValid), 32'd0);
        checkOutput("reset_a_in_ready", 32'(aInReady),  32'd1);

        // Widening: sign/zero extension
        applyStimulus(0, 1'b1, 8'h01, 2'd1, 16'h0001, 1'b0);
        applyStimulus(0, 1'b1, 8'h8A, 2'd1, 16'hFF8A, 1'b0);
        checkOutput("wide_8a_signed", 32'(aOutData), 32'h0000FF8A);
        applyStimulus(0, 1'b1, 8'h8A, 2'd0, 16'h008A, 1'b0);
        applyStimulus(0, 1'b1, 8'h80, 2'd3, 16'hFF80, 1'b0);
        applyStimulus(0, 1'b1, 8'hFF, 2'd2, 16'h00FF, 1'b0);
        applyStimulus(0, 1'b0, 8'h00, 2'd0, 16'h0000, 1'b0);

        // Narrowing: wrap and saturation, including range edges
        applyStimulus(1, 1'b1, 8'h8A, 2'd1, 16'hA, 1'b1);
        applyStimulus(1, 1'b1, 8'h8A, 2'd3, 16'h8, 1'b1);
        applyStimulus(1, 1'b1, 8'h8A, 2'd2, 16'hF, 1'b1);
        applyStimulus(1, 1'b1, 8'h8A, 2'd0, 16'hA, 1'b1);
        applyStimulus(1, 1'b1, 8'hFF, 2'd1, 16'hF, 1'b0);
        applyStimulus(1, 1'b1, 8'hFF, 2'd0, 16'hF, 1'b1);
        applyStimulus(1, 1'b1, 8'hFF, 2'd3, 16'hF, 1'b0);
        applyStimulus(1, 1'b1, 8'h07, 2'd3, 16'h7, 1'b0);
        applyStimulus(1, 1'b1, 8'h08, 2'd3, 16'h7, 1'b1);
        applyStimulus(1, 1'b1, 8'hF8, 2'd3, 16'h8, 1'b0);
        applyStimulus(1, 1'b1, 8'hF7, 2'd3, 16'h8, 1'b1);
        applyStimulus(1, 1'b1, 8'h0F, 2'd2, 16'hF, 1'b0);
        applyStimulus(1, 1'b1, 8'h10, 2'd2, 16'hF, 1'b1);
        applyStimulus(1, 1'b1, 8'h80, 2'd1, 16'h0, 1'b1);
        checkOutput("stats_sat_count",  32'(bCount),  32'd3);
        checkOutput("stats_sat_sticky", 32'(bSticky), 32'd1);

        // Statistics: clear alone, saturation, clear with overflow
        bClear = 1'b1;
        applyStimulus(1, 1'b0, 8'h00, 2'd0, 16'h0, 1'b0);
        bClear = 1'b0;
        checkOutput("clear_count",  32'(bCount),  32'd0);
        checkOutput("clear_sticky", 32'(bSticky), 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1'b1, 8'h8A, 2'd0, 16'hA, 1'b1);
        end
        checkOutput("five_ovf_count",  32'(bCount),  32'd3);
        checkOutput("five_ovf_sticky", 32'(bSticky), 32'd1);
        bClear = 1'b1;
        applyStimulus(1, 1'b1, 8'h8A, 2'd2, 16'hF, 1'b1);
        checkOutput("clear_ovf_count",  32'(bCount),  32'd1);
        checkOutput("clear_ovf_sticky", 32'(bSticky), 32'd1);
        applyStimulus(1, 1'b0, 8'h00, 2'd0, 16'h0, 1'b0);
        bClear = 1'b0;
        checkOutput("clear_again_count",  32'(bCount),  32'd0);
        checkOutput("clear_again_sticky", 32'(bSticky), 32'd0);

        // Back-pressure: first word held, second offered but refused, mode changed meanwhile
        aReady = 1'b0;
        applyStimulus(0, 1'b1, 8'h81, 2'd1, 16'hFF81, 1'b0);
        applyStimulus(0, 1'b1, 8'h22, 2'd0, 16'h0022, 1'b0);
        aMode = 2'd3;
        aExp  = '{data: 16'h0022, ovf: 1'b0};
        tick();
        tick();
        checkOutput("bp_in_ready",  32'(aInReady), 32'd0);
        checkOutput("bp_held_data", 32'(aOutData), 32'h0000FF81);
        aMode  = 2'd0;
        aReady = 1'b1;
        tick();
        checkOutput("bp_release_data", 32'(aOutData), 32'h00000022);
        for (int i = 0; i < 6; i++) begin
            d = 8'(i * 37 + 5);
            m = 2'(i);
            applyStimulus(0, 1'b1, d, m, widenExp(d, m), 1'b0);
            checkOutput("stream_no_bubble", 32'(aOutValid), 32'd1);
        end

        // Randomised valid/ready traffic
        for (int i = 0; i < 40; i++) begin
            aReady = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 3));
            applyStimulus(0, 1'($urandom_range(0, 1)), d, m, widenExp(d, m), 1'b0);
        end
        aReady = 1'b1;
        applyStimulus(0, 1'b0, 8'h00, 2'd0, 16'h0000, 1'b0);

        // Reset mid-stream with a held word and live statistics
        aReady = 1'b0;
        applyStimulus(0, 1'b1, 8'h55, 2'd0, 16'h0055, 1'b0);
        applyStimulus(1, 1'b1, 8'h8A, 2'd0, 16'hA, 1'b1);
        checkOutput("pre_rst_a_valid", 32'(aOutValid), 32'd1);
        rst    = 1'b1;
        bClear = 1'b1;
        tick();
        rst    = 1'b0;
        bClear = 1'b0;
        aValid = 1'b0;
        bValid = 1'b0;
        checkOutput("rst_a_valid",    32'(aOutValid), 32'd0);
        checkOutput("rst_a_data",     32'(aOutData),  32'd0);
        checkOutput("rst_b_count",    32'(bCount),    32'd0);
        checkOutput("rst_b_sticky",   32'(bSticky),   32'd0);
        checkOutput("rst_a_in_ready", 32'(aInReady),  32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
